// File: rtl/cascade_counter.sv
// Multi-digit up/down counter in base BASE with sync clear, clamped parallel load,
// wrap or saturate at the ends of the range, and a runtime target comparator.
module cascade_counter #(
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned DIGIT_W  = 4,
  parameter int unsigned BASE     = 10,
  parameter int unsigned SATURATE = 0
) (
  input  logic                      clk,
  input  logic                      rst_b,
  input  logic                      clr,
  input  logic                      ld,
  input  logic [DIGITS*DIGIT_W-1:0] ld_val,
  input  logic                      en,
  input  logic                      dn,
  input  logic [DIGITS*DIGIT_W-1:0] target,
  output logic [DIGITS*DIGIT_W-1:0] cnt,
  output logic                      at_max,
  output logic                      at_min,
  output logic                      wrap,
  output logic                      tgt_hit,
  output logic                      tgt_pls
);

  localparam int unsigned W = DIGITS * DIGIT_W;
  localparam logic [DIGIT_W-1:0] MaxDigit = DIGIT_W'(BASE - 1);
  localparam logic [DIGIT_W:0]   BaseExt  = (DIGIT_W + 1)'(BASE);

  logic [W-1:0]      cnt_q, cnt_d;
  logic              wrap_q, wrap_d;
  logic              tgt_pls_q, tgt_pls_d;
  logic [DIGITS-1:0] is_max, is_min;
  logic [W-1:0]      up_cnt, dn_cnt, ld_clamped;
  logic              tgt_valid;

  // Per-digit decode: end-of-digit flags, load clamping and target digit validity.
  always_comb begin
    is_max     = '0;
    is_min     = '0;
    ld_clamped = '0;
    tgt_valid  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      is_max[i] = (cnt_q[i*DIGIT_W +: DIGIT_W] == MaxDigit);
      is_min[i] = (cnt_q[i*DIGIT_W +: DIGIT_W] == '0);
      if ({1'b0, ld_val[i*DIGIT_W +: DIGIT_W]} >= BaseExt) begin
        ld_clamped[i*DIGIT_W +: DIGIT_W] = MaxDigit;
      end else begin
        ld_clamped[i*DIGIT_W +: DIGIT_W] = ld_val[i*DIGIT_W +: DIGIT_W];
      end
      if ({1'b0, target[i*DIGIT_W +: DIGIT_W]} >= BaseExt) tgt_valid = 1'b0;
    end
  end

  // Ripple carry/borrow across digits; a digit steps only when all lower digits roll.
  always_comb begin
    logic carry, borrow;
    up_cnt = cnt_q;
    dn_cnt = cnt_q;
    carry  = 1'b1;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        up_cnt[i*DIGIT_W +: DIGIT_W] = is_max[i] ? '0
                                     : cnt_q[i*DIGIT_W +: DIGIT_W] + DIGIT_W'(1);
      end
      if (borrow) begin
        dn_cnt[i*DIGIT_W +: DIGIT_W] = is_min[i] ? MaxDigit
                                     : cnt_q[i*DIGIT_W +: DIGIT_W] - DIGIT_W'(1);
      end
      carry  = carry & is_max[i];
      borrow = borrow & is_min[i];
    end
  end

  assign at_max = &is_max;
  assign at_min = &is_min;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (ld) begin
      cnt_d = ld_clamped;
    end else if (en) begin
      if (!dn) begin
        if (!(at_max && (SATURATE != 0))) begin
          cnt_d  = up_cnt;
          wrap_d = at_max;
        end
      end else begin
        if (!(at_min && (SATURATE != 0))) begin
          cnt_d  = dn_cnt;
          wrap_d = at_min;
        end
      end
    end
    tgt_pls_d = tgt_valid && (cnt_d == target) && (cnt_d != cnt_q);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt_q     <= '0;
      wrap_q    <= 1'b0;
      tgt_pls_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      wrap_q    <= wrap_d;
      tgt_pls_q <= tgt_pls_d;
    end
  end

  assign cnt     = cnt_q;
  assign wrap    = wrap_q;
  assign tgt_pls = tgt_pls_q;
  assign tgt_hit = tgt_valid && (cnt_q == target);

endmodule

// File: tb/tb_cascade_counter.sv
// Directed bench for cascade_counter (2 BCD digits), wrap and saturate variants side by side.
module tb_cascade_counter;

  logic       clk = 1'b0;
  logic       rst_b, clr, ld, en, dn;
  logic [7:0] ld_val, target;
  logic [7:0] cnt_w, cnt_s;
  logic       at_max_w, at_min_w, wrap_w, hit_w, pls_w;
  logic       at_max_s, at_min_s, wrap_s, hit_s, pls_s;

  int checks = 0;
  int failures = 0;
  int m_w = 0;
  int m_s = 0;

  typedef struct {
    logic [7:0] cnt_w;
    logic       wrap_w;
    logic       pls_w;
    logic [7:0] cnt_s;
    logic       wrap_s;
    logic       pls_s;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  cascade_counter #(.DIGITS(2), .DIGIT_W(4), .BASE(10), .SATURATE(0)) dut (
    .clk(clk), .rst_b(rst_b), .clr(clr), .ld(ld), .ld_val(ld_val), .en(en), .dn(dn),
    .target(target), .cnt(cnt_w), .at_max(at_max_w), .at_min(at_min_w), .wrap(wrap_w),
    .tgt_hit(hit_w), .tgt_pls(pls_w)
  );

  cascade_counter #(.DIGITS(2), .DIGIT_W(4), .BASE(10), .SATURATE(1)) dut_sat (
    .clk(clk), .rst_b(rst_b), .clr(clr), .ld(ld), .ld_val(ld_val), .en(en), .dn(dn),
    .target(target), .cnt(cnt_s), .at_max(at_max_s), .at_min(at_min_s), .wrap(wrap_s),
    .tgt_hit(hit_s), .tgt_pls(pls_s)
  );

  function automatic logic [7:0] bcd(input int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  function automatic int load_int(input logic [7:0] b);
    int hi, lo;
    hi = (b[7:4] > 4'd9) ? 9 : int'(b[7:4]);
    lo = (b[3:0] > 4'd9) ? 9 : int'(b[3:0]);
    return hi * 10 + lo;
  endfunction

  function automatic bit hit(input int v, input logic [7:0] t);
    return (t[7:4] < 4'd10) && (t[3:0] < 4'd10) && (bcd(v) == t);
  endfunction

  function automatic int nxt(input int v, input bit sat, input bit c, input bit l,
                             input logic [7:0] lv, input bit e, input bit d, output bit w);
    w = 1'b0;
    if (c) return 0;
    if (l) return load_int(lv);
    if (!e) return v;
    if (!d) begin
      if (v == 99) begin
        if (sat) return 99;
        w = 1'b1;
        return 0;
      end
      return v + 1;
    end
    if (v == 0) begin
      if (sat) return 0;
      w = 1'b1;
      return 99;
    end
    return v - 1;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_comb();
    chk("hit_w", {7'd0, hit_w}, {7'd0, hit(m_w, target)});
    chk("hit_s", {7'd0, hit_s}, {7'd0, hit(m_s, target)});
    chk("at_max_w", {7'd0, at_max_w}, {7'd0, m_w == 99});
    chk("at_min_s", {7'd0, at_min_s}, {7'd0, m_s == 0});
  endtask

  task automatic step(input bit c, input bit l, input logic [7:0] lv, input bit e, input bit d);
    exp_t x;
    bit   w;
    int   nv;
    clr = c; ld = l; ld_val = lv; en = e; dn = d;
    nv = nxt(m_w, 1'b0, c, l, lv, e, d, w);
    x.cnt_w = bcd(nv); x.wrap_w = w; x.pls_w = hit(nv, target) && (nv != m_w);
    m_w = nv;
    nv = nxt(m_s, 1'b1, c, l, lv, e, d, w);
    x.cnt_s = bcd(nv); x.wrap_s = w; x.pls_s = hit(nv, target) && (nv != m_s);
    m_s = nv;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("cnt_w", cnt_w, x.cnt_w);
    chk("wrap_w", {7'd0, wrap_w}, {7'd0, x.wrap_w});
    chk("pls_w", {7'd0, pls_w}, {7'd0, x.pls_w});
    chk("cnt_s", cnt_s, x.cnt_s);
    chk("wrap_s", {7'd0, wrap_s}, {7'd0, x.wrap_s});
    chk("pls_s", {7'd0, pls_s}, {7'd0, x.pls_s});
    check_comb();
  endtask

  initial begin
    rst_b = 1'b0; clr = 1'b0; ld = 1'b0; en = 1'b0; dn = 1'b0;
    ld_val = 8'h00; target = 8'hFF;
    #12;
    chk("rst_cnt", cnt_w, 8'h00);
    chk("rst_wrap", {7'd0, wrap_w}, 8'h00);
    chk("rst_pls", {7'd0, pls_s}, 8'h00);
    check_comb();
    @(negedge clk);
    rst_b = 1'b1;

    // Digit carry and borrow.
    step(0, 1, 8'h09, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 1, 1);
    // Top of range: wrap vs saturate.
    step(0, 1, 8'h99, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1, 0);
    // Bottom of range.
    step(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 8'h00, 1, 1);
    // Load clamping and priority.
    step(0, 1, 8'h3C, 0, 0);
    step(0, 1, 8'hA5, 0, 0);
    step(1, 1, 8'h55, 1, 0);
    step(0, 1, 8'h42, 1, 1);
    // Target pulse and level.
    step(1, 0, 8'h00, 0, 0);
    target = 8'h11;
    for (int i = 0; i < 11; i++) step(0, 0, 8'h00, 1, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    step(0, 1, 8'h11, 0, 0);
    target = 8'h1A;
    #1;
    check_comb();
    target = 8'h12;
    #1;
    check_comb();
    // Asynchronous reset mid-cycle.
    step(0, 1, 8'h45, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 1, 0);
    chk("pre_rst", cnt_w, 8'h47);
    #2;
    rst_b = 1'b0;
    #1;
    m_w = 0;
    m_s = 0;
    chk("async_rst_w", cnt_w, 8'h00);
    chk("async_rst_s", cnt_s, 8'h00);
    chk("async_rst_wrap", {7'd0, wrap_w}, 8'h00);
    @(negedge clk);
    rst_b = 1'b1;
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
